sample_streamer: RTL and testbench
==================================

# sample_streamer

Audio output stage downstream of the pipelined processor. After the processor has written a block of reverberated samples into data RAM, the streamer reads them through a dedicated read port and buffers them in a small prefetch FIFO. It then plays them out as a PWM audio signal at one sample per PWM period. It reports busy/done and latches a sticky underrun flag.

## Interface
- ADDR_W, 32: data RAM address width
- PWM_W, 8: PWM resolution; one sample lasts 2^PWM_W clocks
- FIFO_DEPTH, 4: prefetch FIFO entries (power of two, ≥2)
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- base_addr  in  ADDR_W  word address of first sample, latched on accepted start
- num_samples  in  ADDR_W  sample count, latched on accepted start
- mem_rd_en  out  1  read strobe to data RAM
- mem_addr  out  ADDR_W  read address
- mem_rdata  in  32  read data, valid exactly 1 cycle after mem_rd_en; sample is the signed value in bits [15:0]
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at end of block
- underrun  out  1  sticky; set when FIFO empty at a sample boundary, cleared on accepted start
- level  out  PWM_W  current PWM duty value
- pwm_out  out  1  PWM audio output

## Operation
- States: IDLE, PRIME, PLAY, FINISH.
- IDLE: start=1 latches base/len and clears the counters, the FIFO and underrun. If num_samples=0, go to FINISH; else go to PRIME. start is ignored while busy.
- Fetcher runs in PRIME and PLAY. It asserts mem_rd_en, with mem_addr = base + fetched, when fetched < len and (occupancy + outstanding) < FIFO_DEPTH. outstanding is 0 or 1.
- Each returned word is pushed next cycle. Conversion: level = {~rdata[15], rdata[14:16-PWM_W]}, i.e. signed → offset-binary, top PWM_W bits.
- PRIME → PLAY when the FIFO is full, or when fetched = len with no read outstanding. pwm_cnt is cleared on entry.
- PLAY: pwm_cnt counts 0..2^PWM_W−1 and wraps. At pwm_cnt=0:
  - if played = len → FINISH;
  - else if FIFO non-empty → pop into level and increment played;
  - else → level = 2^(PWM_W−1) (midscale), set underrun, and do not increment played (the sample is retried next period).
- pwm_out = (pwm_cnt < level), registered. level 0 gives constant low.
- FINISH: done=1 for one cycle, level returns to midscale, then IDLE.
- Arithmetic: fetched/played are ADDR_W-bit unsigned; mem_addr wraps modulo 2^ADDR_W.

## Timing
- Reset values: mem_rd_en=0, mem_addr=0, busy=0, done=0, underrun=0, level=2^(PWM_W−1), pwm_out=0, state IDLE, FIFO empty.
- busy rises the cycle after the accepted start.
- The first mem_rd_en is asserted the cycle after start.
- Reads issue at most every 2 cycles: there is a one-read round trip.
- A FIFO push and pop in the same cycle are both honoured; occupancy is unchanged.
- A pop at pwm_cnt=0 updates level in that same clock edge, so pwm_out reflects it from pwm_cnt=1 onward.
- The final sample plays a full period. done pulses 2^PWM_W+1 clocks after its pop, and busy falls with done.
- Reset asserted mid-block aborts immediately to reset values. A read in flight is discarded.

## Structure
- Package streamer_pkg holds the state enum (IDLE, PRIME, PLAY, FINISH), the MIDSCALE constant, and a to_level() conversion function.
- One sub-module, sample_fifo: synchronous FIFO parameterised by width and depth, with push/pop/full/empty/count and a clear input. It uses the same clk/rst.
- The top level holds the FSM, fetcher, counters and PWM.

## Test plan
- num_samples=3, base=0x10, RAM[0x10..0x12] = 0x0000, 0x7FFF, 0x8000 → reads at 0x10, 0x11, 0x12 only. level sequence is 0x80, 0xFF, 0x00, each held 256 clocks. done pulses once, underrun stays 0.
- num_samples=0 → done pulses one cycle after start, no mem_rd_en, busy pulses one cycle.
- num_samples=10 → at most 4 entries buffered, mem_rd_en never asserted while full, exactly 10 reads.
- mem_rdata held invalid by forcing the FIFO empty during PLAY (stall the fetcher via RAM model) → level=0x80 for that period, underrun=1 and stays 1 through done. The next start clears it.
- Second start pulse while busy → ignored; base/len unchanged, read count unchanged.
- rst low mid-PLAY → all outputs at reset values asynchronously. A new start plays the block from base with a fresh FIFO.

Source files
------------

// File: rtl/streamer_pkg.sv
// Shared types and helpers for the sample streamer: FSM encoding, midscale
// constant and the signed-sample to offset-binary conversion.
package streamer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRIME  = 2'd1,
    PLAY   = 2'd2,
    FINISH = 2'd3
  } streamer_state_e;

  // Full 16-bit offset-binary midscale; callers keep the top PWM_W bits.
  localparam logic [15:0] MIDSCALE = 16'h8000;

  // Two's-complement sample to offset-binary by flipping the sign bit.
  function automatic logic [15:0] to_level(input logic [15:0] sample);
    return {~sample[15], sample[14:0]};
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous prefetch FIFO with a clear input; simultaneous push and pop
// are both honoured, including when full.
module sample_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  logic [WIDTH-1:0]         pushData,
  input  logic                     pop,
  output logic [WIDTH-1:0]         popData,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic [AW:0]      occ;
  logic             doPush;
  logic             doPop;

  assign full    = (occ == (AW+1)'(DEPTH));
  assign empty   = (occ == '0);
  assign count   = occ;
  assign popData = mem[rdPtr];
  assign doPop   = pop && !empty;
  assign doPush  = push && (!full || doPop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      occ   <= '0;
    end else if (clear) begin
      wrPtr <= '0;
      rdPtr <= '0;
      occ   <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + AW'(1);
      if (doPop)  rdPtr <= rdPtr + AW'(1);
      case ({doPush, doPop})
        2'b10:   occ <= occ + (AW+1)'(1);
        2'b01:   occ <= occ - (AW+1)'(1);
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (doPush && !clear) mem[wrPtr] <= pushData;
  end

endmodule

// File: rtl/sample_streamer.sv
// Audio output stage: fetches a block of samples from data RAM into a prefetch
// FIFO and plays one sample per PWM period, with busy/done and sticky underrun.
module sample_streamer
  import streamer_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int PWM_W      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] num_samples,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              underrun,
  output logic [PWM_W-1:0]  level,
  output logic              pwm_out,
  output streamer_state_e   dbgState
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [PWM_W-1:0] MID = MIDSCALE[15 -: PWM_W];

  streamer_state_e   state, stateNext;
  logic [ADDR_W-1:0] baseReg, lenReg, fetched, played;
  logic              outstanding;
  logic [PWM_W-1:0]  pwmCnt, pwmCntNext, levelNext;
  logic              accept, fetchActive, rdGo;
  logic              fifoPop, playedInc, setUnderrun;
  logic              fifoFull, fifoEmpty;
  logic [CW-1:0]     fifoCount;
  logic [PWM_W-1:0]  fifoHead;
  logic [15:0]       converted;
  logic              unusedBits;

  assign accept      = (state == IDLE) && start;
  assign fetchActive = (state == PRIME) || (state == PLAY);
  // One read in flight at most, so occupancy+outstanding reduces to occupancy.
  assign rdGo        = fetchActive && !outstanding && (fetched < lenReg) &&
                       (fifoCount < CW'(FIFO_DEPTH));
  assign mem_rd_en   = rdGo;
  assign mem_addr    = baseReg + fetched;
  assign converted   = to_level(mem_rdata[15:0]);
  assign unusedBits  = ^{mem_rdata[31:16], converted};
  assign busy        = (state != IDLE);
  assign done        = (state == FINISH);
  assign dbgState    = state;

  sample_fifo #(
    .WIDTH(PWM_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clear   (accept),
    .push    (outstanding),
    .pushData(converted[15 -: PWM_W]),
    .pop     (fifoPop),
    .popData (fifoHead),
    .full    (fifoFull),
    .empty   (fifoEmpty),
    .count   (fifoCount)
  );

  always_comb begin
    stateNext   = state;
    levelNext   = level;
    pwmCntNext  = pwmCnt;
    fifoPop     = 1'b0;
    playedInc   = 1'b0;
    setUnderrun = 1'b0;
    case (state)
      IDLE: begin
        if (start) stateNext = (num_samples == '0) ? FINISH : PRIME;
      end
      PRIME: begin
        if (fifoFull || ((fetched == lenReg) && !outstanding)) begin
          stateNext  = PLAY;
          pwmCntNext = '0;
        end
      end
      PLAY: begin
        pwmCntNext = pwmCnt + PWM_W'(1);
        if (pwmCnt == '0) begin
          if (played == lenReg) begin
            stateNext = FINISH;
          end else if (!fifoEmpty) begin
            fifoPop   = 1'b1;
            levelNext = fifoHead;
            playedInc = 1'b1;
          end else begin
            // Starved: output silence and retry the same sample next period.
            levelNext   = MID;
            setUnderrun = 1'b1;
          end
        end
      end
      FINISH: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
    if (stateNext == FINISH) levelNext = MID;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      baseReg     <= '0;
      lenReg      <= '0;
      fetched     <= '0;
      played      <= '0;
      outstanding <= 1'b0;
      pwmCnt      <= '0;
      level       <= MID;
      pwm_out     <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      state       <= stateNext;
      pwmCnt      <= pwmCntNext;
      level       <= levelNext;
      outstanding <= rdGo;
      // Compare next-cycle values so a new level shows from pwm_cnt=1.
      pwm_out     <= (stateNext == PLAY) && (pwmCntNext < levelNext);
      if (accept) begin
        baseReg  <= base_addr;
        lenReg   <= num_samples;
        fetched  <= '0;
        played   <= '0;
        underrun <= 1'b0;
      end else begin
        if (rdGo)        fetched  <= fetched + ADDR_W'(1);
        if (playedInc)   played   <= played + ADDR_W'(1);
        if (setUnderrun) underrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sample_streamer.sv
// Scoreboard bench for sample_streamer: RAM model, expected read addresses and
// per-period level/duty expectations, done latency and underrun behaviour.
`timescale 1ns/1ps
module tb_sample_streamer;
  import streamer_pkg::*;

  localparam int ADDR_W = 32;
  localparam int PWM_W  = 8;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [ADDR_W-1:0] num_samples = '0;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_rdata = '0;
  logic              busy, done, underrun, pwm_out;
  logic [PWM_W-1:0]  level;
  streamer_state_e   dbgState;

  sample_streamer #(.ADDR_W(ADDR_W), .PWM_W(PWM_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .num_samples(num_samples), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .busy(busy), .done(done), .underrun(underrun),
    .level(level), .pwm_out(pwm_out), .dbgState(dbgState)
  );

  // clock / reset
  always #5 clk = ~clk;

  // RAM model: data valid one cycle after the read strobe
  logic [31:0] ram [256];
  always @(posedge clk) if (mem_rd_en) mem_rdata <= ram[mem_addr[7:0]];

  // scoreboard state
  logic [PWM_W:0]    exp_q[$];      // {isSample, level}
  logic [ADDR_W-1:0] addrExpQ[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic checkVal(input string tag, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [PWM_W-1:0] refLevel(input logic [31:0] word);
    int s;
    s = int'($signed(word[15:0])) + 32768;
    return PWM_W'(s >> (16 - PWM_W));
  endfunction

  // monitor
  int              cyc = 0;
  logic [PWM_W-1:0] tbCnt = '0;
  streamer_state_e prevState = IDLE;
  logic            havePeriod = 1'b0;
  logic            prevRd = 1'b0;
  logic [PWM_W:0]  curExp = '0;
  int              highCnt = 0;
  int              inFlight = 0;
  int              doneCnt = 0;
  int              lastPopCyc = -1;

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      havePeriod = 1'b0; inFlight = 0; prevRd = 1'b0;
      prevState = IDLE; tbCnt = '0; lastPopCyc = -1;
    end else begin
      if (dbgState == PLAY) begin
        tbCnt = (prevState == PLAY) ? tbCnt + PWM_W'(1) : '0;
        if (tbCnt == PWM_W'(1)) begin
          checkVal("level_avail", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            curExp = exp_q.pop_front();
            checkVal("level", level, curExp[PWM_W-1:0]);
            if (curExp[PWM_W]) begin
              inFlight--;
              lastPopCyc = cyc - 1;
            end
            havePeriod = 1'b1;
            highCnt = 0;
          end
        end
        if (havePeriod) highCnt += int'(pwm_out);
        if (tbCnt == '0 && havePeriod) begin
          checkVal("duty", highCnt, curExp[PWM_W-1:0]);
          havePeriod = 1'b0;
        end
      end
      if (mem_rd_en) begin
        checkVal("rd_gap", prevRd, 0);
        checkVal("fifo_bound", inFlight < DEPTH, 1);
        checkVal("reads_left", addrExpQ.size() > 0, 1);
        if (addrExpQ.size() > 0) checkVal("rd_addr", mem_addr, addrExpQ.pop_front());
        inFlight++;
      end
      prevRd = mem_rd_en;
      if (done) begin
        doneCnt++;
        if (lastPopCyc >= 0) checkVal("done_lat", cyc - lastPopCyc, 257);
        lastPopCyc = -1;
      end
      prevState = dbgState;
    end
  end

  // driver tasks
  task automatic startBlock(input logic [ADDR_W-1:0] base, input int len, input int uPos);
    for (int i = 0; i < len; i++) begin
      addrExpQ.push_back(base + ADDR_W'(i));
      if (i == uPos) exp_q.push_back({1'b0, 8'h80});
      exp_q.push_back({1'b1, refLevel(ram[8'(base + ADDR_W'(i))])});
    end
    base_addr = base;
    num_samples = ADDR_W'(len);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDone(input int maxCyc);
    int n = 0;
    while (!done && n < maxCyc) begin
      @(negedge clk);
      n++;
    end
    checkVal("done_seen", done, 1);
  endtask

  task automatic waitState(input streamer_state_e st, input int maxCyc);
    int n = 0;
    while (dbgState != st && n < maxCyc) begin
      @(negedge clk);
      n++;
    end
    checkVal("state_reached", dbgState, st);
  endtask

  task automatic checkResetValues(input string tag);
    checkVal({tag, "_rd_en"}, mem_rd_en, 0);
    checkVal({tag, "_addr"}, mem_addr, 0);
    checkVal({tag, "_busy"}, busy, 0);
    checkVal({tag, "_done"}, done, 0);
    checkVal({tag, "_underrun"}, underrun, 0);
    checkVal({tag, "_level"}, level, 8'h80);
    checkVal({tag, "_pwm"}, pwm_out, 0);
    checkVal({tag, "_state"}, dbgState, IDLE);
  endtask

  task automatic checkEnd(input int doneBefore);
    checkVal("busy_at_done", busy, 1);
    @(negedge clk);
    checkVal("done_pulse", done, 0);
    checkVal("busy_fall", busy, 0);
    @(negedge clk);
    checkVal("done_count", doneCnt - doneBefore, 1);
    checkVal("addr_q_empty", addrExpQ.size(), 0);
    checkVal("level_q_empty", exp_q.size(), 0);
  endtask

  initial begin
    int d0;
    for (int i = 0; i < 256; i++) ram[i] = $urandom;
    ram[8'h10] = 32'h0000_0000;
    ram[8'h11] = 32'h0000_7FFF;
    ram[8'h12] = 32'hFFFF_8000;

    // reset
    repeat (3) @(negedge clk);
    checkResetValues("rst_hold");
    rst = 1'b1;
    @(negedge clk);
    checkResetValues("rst_rel");

    // three-sample block: levels 0x80, 0xFF, 0x00
    d0 = doneCnt;
    startBlock(32'h10, 3, -1);
    checkVal("busy_rise", busy, 1);
    checkVal("first_rd", mem_rd_en, 1);
    waitDone(2000);
    checkVal("underrun_a", underrun, 0);
    checkEnd(d0);

    // empty block
    d0 = doneCnt;
    startBlock(32'h30, 0, -1);
    checkVal("zero_done", done, 1);
    checkVal("zero_busy", busy, 1);
    checkVal("zero_rd", mem_rd_en, 0);
    checkEnd(d0);

    // ten samples with an ignored second start while busy
    d0 = doneCnt;
    startBlock(32'h40, 10, -1);
    repeat (20) @(negedge clk);
    base_addr = 32'h90;
    num_samples = 32'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkVal("busy_hold", busy, 1);
    waitDone(5000);
    checkEnd(d0);

    // starve the fetcher after priming so the fifth period underruns
    d0 = doneCnt;
    startBlock(32'h80, 6, 4);
    waitState(PLAY, 100);
    force dut.rdGo = 1'b0;
    for (int n = 0; n < 2000 && !underrun; n++) @(negedge clk);
    checkVal("underrun_set", underrun, 1);
    release dut.rdGo;
    waitDone(4000);
    checkVal("underrun_at_done", underrun, 1);
    checkEnd(d0);
    checkVal("underrun_sticky", underrun, 1);

    // new start clears underrun; reset mid-PLAY aborts
    for (int i = 0; i < 5; i++) ram[8'h20 + i] = $urandom;
    startBlock(32'h20, 5, -1);
    checkVal("underrun_clr", underrun, 0);
    waitState(PLAY, 100);
    repeat (300) @(negedge clk);
    #2 rst = 1'b0;
    #1 checkResetValues("rst_mid");
    exp_q.delete();
    addrExpQ.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) ram[8'h20 + i] = $urandom;
    d0 = doneCnt;
    startBlock(32'h20, 3, -1);
    checkVal("restart_rd", mem_rd_en, 1);
    checkVal("restart_addr", mem_addr, 32'h20);
    waitDone(2000);
    checkVal("underrun_restart", underrun, 0);
    checkEnd(d0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
